fetch_queue: RTL and testbench

- Instruction fetch buffer that sits directly downstream of the program counter / fetch stage.
- Accepts one fetch packet per cycle. A packet has NUM_UOPS 32-bit instruction slots, each with a valid mask bit, PC, branch ID and prediction bit.
- Compacts the valid slots into an in-order circular queue and presents up to NUM_OUT oldest entries to decode, under a ready handshake.
- Generates the stall back-pressure used to drive the fetch stage's en0/en1. Flushes on branch mispredict or redirect.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_compact.sv | 23 ++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue and the decode-side instruction buffer.
package fetch_queue_pkg;

    localparam logic [5:0] BRANCH_ID_NONE = 6'd63;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  branch_id;
        logic        branch_pred;
    } entry_t;

endpackage

// File: rtl/fetch_queue_compact.sv
// Maps a slot valid mask to per-slot write offsets (count of valid slots below
// each slot) and the total number of valid slots.
module fq_compact #(
    parameter  int NUM_UOPS = 2,
    localparam int OFF_W    = $clog2(NUM_UOPS + 1)
) (
    input  logic [NUM_UOPS-1:0]            valid_mask,
    output logic [NUM_UOPS-1:0][OFF_W-1:0] offset,
    output logic [OFF_W-1:0]               n_valid
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_UOPS; i++) begin
            offset[i] = acc;
            acc       = acc + OFF_W'(valid_mask[i]);
        end
        n_valid = acc;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch buffer: compacts valid fetch slots into a circular queue and presents
// the oldest NUM_OUT entries to decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int NUM_UOPS    = 2,
    parameter int NUM_OUT     = 2,
    parameter int DEPTH       = 8,
    parameter int FULL_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IN_clear,
    input  logic                  IN_en,
    input  logic [NUM_UOPS-1:0]   IN_instrValid,
    input  logic [NUM_UOPS*32-1:0] IN_pc,
    input  logic [NUM_UOPS*32-1:0] IN_instr,
    input  logic [NUM_UOPS*6-1:0] IN_branchID,
    input  logic [NUM_UOPS-1:0]   IN_branchPred,
    output logic                  OUT_full,
    output logic                  OUT_overflow,
    input  logic                  IN_ready,
    output logic [NUM_OUT-1:0]    OUT_valid,
    output logic [NUM_OUT*32-1:0] OUT_pc,
    output logic [NUM_OUT*32-1:0] OUT_instr,
    output logic [NUM_OUT*6-1:0]  OUT_branchID,
    output logic [NUM_OUT-1:0]    OUT_branchPred
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(NUM_UOPS + 1);

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    entry_t           mem [DEPTH];

    logic [NUM_UOPS-1:0][OFF_W-1:0] wr_off;
    logic [OFF_W-1:0]               valid_cnt;
    entry_t                         in_entry [NUM_UOPS];

    logic [CNT_W-1:0] n_show, n_deq, n_enq, free_space;
    logic             accept;

    fq_compact #(.NUM_UOPS(NUM_UOPS)) u_compact (
        .valid_mask (IN_instrValid),
        .offset     (wr_off),
        .n_valid    (valid_cnt)
    );

    // Handshake: every lane with OUT_valid set is consumed together when IN_ready
    // is high; there is no per-lane acceptance. Same-cycle dequeue frees space.
    always_comb begin
        n_show     = (count > CNT_W'(NUM_OUT)) ? CNT_W'(NUM_OUT) : count;
        n_deq      = IN_ready ? n_show : '0;
        n_enq      = IN_en ? CNT_W'(valid_cnt) : '0;
        free_space = CNT_W'(DEPTH) - count + n_deq;
        accept     = (n_enq <= free_space);
        OUT_full   = (CNT_W'(DEPTH) - count) < CNT_W'(FULL_THRESH);
        for (int k = 0; k < NUM_OUT; k++) begin
            OUT_valid[k] = (count > CNT_W'(k));
        end
        for (int i = 0; i < NUM_UOPS; i++) begin
            in_entry[i] = '{pc:          IN_pc[i*32 +: 32],
                            instr:       IN_instr[i*32 +: 32],
                            branch_id:   IN_branchID[i*6 +: 6],
                            branch_pred: IN_branchPred[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || IN_clear) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            OUT_overflow <= 1'b0;
        end else begin
            head         <= head + PTR_W'(n_deq);
            OUT_overflow <= !accept;
            if (accept) begin
                tail  <= tail + PTR_W'(n_enq);
                count <= count + n_enq - n_deq;
            end else begin
                count <= count - n_deq;
            end
        end
    end

    // A dropped packet writes nothing, so storage only changes on accept.
    always_ff @(posedge clk) begin
        if (!rst && !IN_clear && IN_en && accept) begin
            for (int i = 0; i < NUM_UOPS; i++) begin
                if (IN_instrValid[i]) begin
                    mem[tail + PTR_W'(wr_off[i])] <= in_entry[i];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_rd
        logic [PTR_W-1:0] rd_idx;
        assign rd_idx                  = head + PTR_W'(k);
        assign OUT_pc[k*32 +: 32]      = mem[rd_idx].pc;
        assign OUT_instr[k*32 +: 32]   = mem[rd_idx].instr;
        assign OUT_branchID[k*6 +: 6]  = mem[rd_idx].branch_id;
        assign OUT_branchPred[k]       = mem[rd_idx].branch_pred;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written wrap sequence and
// random traffic checked against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int NUM_UOPS    = 2;
    localparam int NUM_OUT     = 2;
    localparam int DEPTH       = 8;
    localparam int FULL_THRESH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   IN_clear, IN_en, IN_ready;
    logic [NUM_UOPS-1:0]    IN_instrValid, IN_branchPred;
    logic [NUM_UOPS*32-1:0] IN_pc, IN_instr;
    logic [NUM_UOPS*6-1:0]  IN_branchID;
    logic                   OUT_full, OUT_overflow;
    logic [NUM_OUT-1:0]     OUT_valid, OUT_branchPred;
    logic [NUM_OUT*32-1:0]  OUT_pc, OUT_instr;
    logic [NUM_OUT*6-1:0]   OUT_branchID;

    int n_cmp = 0;
    int n_bad = 0;

    entry_t ref_q[$];
    logic   ref_ovf;

    typedef struct {
        logic        en, clear, ready;
        logic [1:0]  mask;
        logic [31:0] pc0, pc1;
        logic [5:0]  bid1;
        logic        pred1;
        logic [1:0]  exp_valid;
        logic        exp_full, exp_ovf;
        logic [31:0] exp_pc0;
        logic [5:0]  exp_bid0;
        logic        exp_pred0;
    } vec_t;
    vec_t vq[$];

    fetch_queue #(
        .NUM_UOPS(NUM_UOPS), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH), .FULL_THRESH(FULL_THRESH)
    ) dut (
        .clk(clk), .rst(rst), .IN_clear(IN_clear), .IN_en(IN_en),
        .IN_instrValid(IN_instrValid), .IN_pc(IN_pc), .IN_instr(IN_instr),
        .IN_branchID(IN_branchID), .IN_branchPred(IN_branchPred),
        .OUT_full(OUT_full), .OUT_overflow(OUT_overflow), .IN_ready(IN_ready),
        .OUT_valid(OUT_valid), .OUT_pc(OUT_pc), .OUT_instr(OUT_instr),
        .OUT_branchID(OUT_branchID), .OUT_branchPred(OUT_branchPred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic en, input logic clr, input logic rdy, input logic [1:0] mask,
                          input logic [31:0] pc0, input logic [31:0] pc1,
                          input logic [5:0] bid0, input logic [5:0] bid1,
                          input logic pred0, input logic pred1);
        IN_en = en; IN_clear = clr; IN_ready = rdy; IN_instrValid = mask;
        IN_pc = {pc1, pc0}; IN_instr = {~pc1, ~pc0};
        IN_branchID = {bid1, bid0}; IN_branchPred = {pred1, pred0};
    endtask

    // Reference: a plain queue of entries updated from the documented rules.
    task automatic model_update();
        entry_t inc[$];
        int ndeq;
        if (rst || IN_clear) begin
            ref_q.delete();
            ref_ovf = 1'b0;
        end else begin
            ndeq = IN_ready ? ((ref_q.size() < NUM_OUT) ? ref_q.size() : NUM_OUT) : 0;
            if (IN_en)
                for (int s = 0; s < NUM_UOPS; s++)
                    if (IN_instrValid[s])
                        inc.push_back('{pc: IN_pc[s*32 +: 32], instr: IN_instr[s*32 +: 32],
                                        branch_id: IN_branchID[s*6 +: 6], branch_pred: IN_branchPred[s]});
            ref_ovf = (inc.size() > DEPTH - ref_q.size() + ndeq);
            repeat (ndeq) void'(ref_q.pop_front());
            if (!ref_ovf) foreach (inc[i]) ref_q.push_back(inc[i]);
        end
    endtask

    task automatic check_model();
        int n;
        logic [NUM_OUT-1:0] ev;
        n = ref_q.size();
        for (int k = 0; k < NUM_OUT; k++) ev[k] = (n > k);
        chk("m_valid", 32'(OUT_valid), 32'(ev));
        chk("m_full", 32'(OUT_full), 32'((DEPTH - n) < FULL_THRESH));
        chk("m_ovf", 32'(OUT_overflow), 32'(ref_ovf));
        for (int k = 0; k < NUM_OUT; k++) begin
            if (k < n) begin
                chk("m_pc", OUT_pc[k*32 +: 32], ref_q[k].pc);
                chk("m_instr", OUT_instr[k*32 +: 32], ref_q[k].instr);
                chk("m_bid", 32'(OUT_branchID[k*6 +: 6]), 32'(ref_q[k].branch_id));
                chk("m_pred", 32'(OUT_branchPred[k]), 32'(ref_q[k].branch_pred));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 2'b00, 0, 0, BRANCH_ID_NONE, BRANCH_ID_NONE, 0, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic en, input logic clr, input logic rdy, input logic [1:0] mask,
                           input logic [31:0] pc0, input logic [31:0] pc1, input logic [5:0] bid1,
                           input logic pred1, input logic [1:0] ev, input logic ef, input logic eo,
                           input logic [31:0] epc, input logic [5:0] ebid, input logic epred);
        vec_t v;
        v = '{en, clr, rdy, mask, pc0, pc1, bid1, pred1, ev, ef, eo, epc, ebid, epred};
        vq.push_back(v);
    endtask

    initial begin
        int next_pc;
        logic [31:0] r0, r1;

        // Directed vectors: reset/idle, first packet, compaction, fill, overflow,
        // full-boundary simultaneous enq/deq, flush with same-cycle enqueue.
        add_vec(0,0,0,2'b00, 32'h000, 32'h000, 63, 0, 2'b00, 0, 0, 32'h000, 63, 0);
        add_vec(1,0,0,2'b11, 32'h100, 32'h104, 63, 0, 2'b11, 0, 0, 32'h100, 63, 0);
        add_vec(0,0,1,2'b00, 32'h000, 32'h000, 63, 0, 2'b00, 0, 0, 32'h000, 63, 0);
        add_vec(1,0,0,2'b10, 32'h000, 32'h20C,  5, 1, 2'b01, 0, 0, 32'h20C,  5, 1);
        add_vec(0,0,1,2'b00, 32'h000, 32'h000, 63, 0, 2'b00, 0, 0, 32'h000, 63, 0);
        add_vec(1,0,0,2'b11, 32'h300, 32'h304, 63, 0, 2'b11, 0, 0, 32'h300, 63, 0);
        add_vec(1,0,0,2'b11, 32'h308, 32'h30C, 63, 0, 2'b11, 0, 0, 32'h300, 63, 0);
        add_vec(1,0,0,2'b11, 32'h310, 32'h314, 63, 0, 2'b11, 1, 0, 32'h300, 63, 0);
        add_vec(1,0,0,2'b11, 32'h318, 32'h31C, 63, 0, 2'b11, 1, 0, 32'h300, 63, 0);
        add_vec(1,0,0,2'b11, 32'h320, 32'h324, 63, 0, 2'b11, 1, 1, 32'h300, 63, 0);
        add_vec(0,0,0,2'b00, 32'h000, 32'h000, 63, 0, 2'b11, 1, 0, 32'h300, 63, 0);
        add_vec(1,0,1,2'b11, 32'h340, 32'h344, 63, 0, 2'b11, 1, 0, 32'h308, 63, 0);
        add_vec(1,0,1,2'b00, 32'h000, 32'h000, 63, 0, 2'b11, 1, 0, 32'h310, 63, 0);
        add_vec(1,1,1,2'b11, 32'h350, 32'h354, 63, 0, 2'b00, 0, 0, 32'h000, 63, 0);
        add_vec(0,0,0,2'b00, 32'h000, 32'h000, 63, 0, 2'b00, 0, 0, 32'h000, 63, 0);

        ref_ovf = 1'b0;
        do_reset();
        foreach (vq[i]) begin
            set_in(vq[i].en, vq[i].clear, vq[i].ready, vq[i].mask, vq[i].pc0, vq[i].pc1,
                   BRANCH_ID_NONE, vq[i].bid1, 1'b0, vq[i].pred1);
            step();
            chk($sformatf("v%0d_valid", i), 32'(OUT_valid), 32'(vq[i].exp_valid));
            chk($sformatf("v%0d_full", i), 32'(OUT_full), 32'(vq[i].exp_full));
            chk($sformatf("v%0d_ovf", i), 32'(OUT_overflow), 32'(vq[i].exp_ovf));
            if (vq[i].exp_valid[0]) begin
                chk($sformatf("v%0d_pc0", i), OUT_pc[31:0], vq[i].exp_pc0);
                chk($sformatf("v%0d_bid0", i), 32'(OUT_branchID[5:0]), 32'(vq[i].exp_bid0));
                chk($sformatf("v%0d_pred0", i), 32'(OUT_branchPred[0]), 32'(vq[i].exp_pred0));
            end
        end

        // Flush at count 5 with a same-cycle enqueue: nothing may survive.
        do_reset();
        set_in(1, 0, 0, 2'b11, 32'h400, 32'h404, 63, 63, 0, 0); step();
        set_in(1, 0, 0, 2'b11, 32'h408, 32'h40C, 63, 63, 0, 0); step();
        set_in(1, 0, 0, 2'b01, 32'h410, 32'h414, 63, 63, 0, 0); step();
        set_in(1, 1, 0, 2'b11, 32'h418, 32'h41C, 63, 63, 0, 0); step();
        chk("flush_valid", 32'(OUT_valid), 32'h0);
        set_in(0, 0, 0, 2'b00, 0, 0, 63, 63, 0, 0); step();
        chk("flush_stays_empty", 32'(OUT_valid), 32'h0);

        // Steady 2-in / 2-out stream across the pointer wrap.
        do_reset();
        next_pc = 0;
        for (int i = 0; i < 12; i++) begin
            set_in(i < 10, 0, 1, 2'b11, 32'(8*i), 32'(8*i + 4), 63, 63, 0, 0);
            for (int k = 0; k < NUM_OUT; k++)
                if (OUT_valid[k]) begin
                    chk("wrap_pc", OUT_pc[k*32 +: 32], 32'(next_pc));
                    next_pc += 4;
                end
            step();
        end
        chk("wrap_total", 32'(next_pc), 32'd80);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r0 = $urandom & 32'hFFFF_FFFE;
            r1 = $urandom & 32'hFFFF_FFFE;
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                   $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), r0, r1,
                   6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            IN_instr = {$urandom, $urandom};
            rst = ($urandom_range(0, 150) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
